// File: rtl/rtl_upacc_ctrl.sv
// Host-to-micro-peripheral access controller: one host request becomes one downstream strobe.
// Optional macro UPACC_TIMEOUT_EN adds a wait-cycle timeout that ends the access through ERR.
module rtl_upacc_ctrl #(
    parameter int unsigned ADDRBIT = 5,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TOUTBIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hcs,
    input  logic               hrnw,
    input  logic [ADDRBIT-1:0] ha,
    input  logic [WIDTH-1:0]   hdi,
    output logic [WIDTH-1:0]   hdo,
    output logic               hack,
    output logic               herr,
    output logic               hbusy,
    output logic               upen,
    output logic [ADDRBIT-1:0] upa,
    output logic               upws,
    output logic               uprs,
    output logic [WIDTH-1:0]   updi,
    input  logic [WIDTH-1:0]   updo,
    input  logic               uprdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state, state_n;
    logic               dir_rd, dir_rd_n;
    logic [ADDRBIT-1:0] upa_n;
    logic [WIDTH-1:0]   updi_n, hdo_n;
    logic               upen_n, upws_n, uprs_n, hack_n, herr_n, hbusy_n;
    logic               tout_c;

`ifdef UPACC_TIMEOUT_EN
    logic [TOUTBIT-1:0] tcnt, tcnt_n;

    // tcnt holds the index of the current WAIT cycle; reaching all ones is the limit
    assign tout_c = (tcnt == {TOUTBIT{1'b1}});

    always_comb begin
        tcnt_n = tcnt;
        if (state_n == S_REQ) begin
            tcnt_n = '0;
        end else if ((state == S_REQ || state == S_WAIT) && state_n == S_WAIT) begin
            tcnt_n = tcnt + TOUTBIT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt_n;
        end
    end
`else
    assign tout_c = 1'b0;
`endif

    // Next state plus next value of every registered output
    always_comb begin
        state_n  = state;
        dir_rd_n = dir_rd;
        upa_n    = upa;
        updi_n   = updi;
        hdo_n    = hdo;

        case (state)
            S_IDLE: begin
                if (hcs) begin
                    state_n  = S_REQ;
                    dir_rd_n = hrnw;
                    upa_n    = ha;
                    updi_n   = hdi;
                end
            end
            S_REQ, S_WAIT: begin
                if (uprdy) begin
                    state_n = S_DONE;
                    if (dir_rd) begin
                        hdo_n = updo;
                    end
                end else if (state == S_WAIT && tout_c) begin
                    state_n = S_ERR;
                    if (dir_rd) begin
                        hdo_n = '0;
                    end
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        upen_n  = (state_n == S_REQ) || (state_n == S_WAIT);
        upws_n  = (state_n == S_REQ) && !dir_rd_n;
        uprs_n  = (state_n == S_REQ) && dir_rd_n;
        hack_n  = (state_n == S_DONE);
        herr_n  = (state_n == S_ERR);
        hbusy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            dir_rd <= 1'b0;
            upa    <= '0;
            updi   <= '0;
            hdo    <= '0;
            upen   <= 1'b0;
            upws   <= 1'b0;
            uprs   <= 1'b0;
            hack   <= 1'b0;
            herr   <= 1'b0;
            hbusy  <= 1'b0;
        end else begin
            state  <= state_n;
            dir_rd <= dir_rd_n;
            upa    <= upa_n;
            updi   <= updi_n;
            hdo    <= hdo_n;
            upen   <= upen_n;
            upws   <= upws_n;
            uprs   <= uprs_n;
            hack   <= hack_n;
            herr   <= herr_n;
            hbusy  <= hbusy_n;
        end
    end

endmodule

// File: tb/tb_rtl_upacc_ctrl.sv
// Self-checking bench for rtl_upacc_ctrl: transaction-level model, directed cases, random traffic.
module tb_rtl_upacc_ctrl;

    localparam int unsigned AB    = 5;
    localparam int unsigned W     = 32;
    localparam int unsigned TB    = 4;
    localparam int          LIMIT = (1 << TB) - 1;
`ifdef UPACC_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    logic          clk, rst, hcs, hrnw, uprdy;
    logic [AB-1:0] ha;
    logic [W-1:0]  hdi, updo;
    logic [W-1:0]  hdo, updi;
    logic [AB-1:0] upa;
    logic          hack, herr, hbusy, upen, upws, uprs;

    rtl_upacc_ctrl #(.ADDRBIT(AB), .WIDTH(W), .TOUTBIT(TB)) dut (
        .clk(clk), .rst(rst), .hcs(hcs), .hrnw(hrnw), .ha(ha), .hdi(hdi),
        .hdo(hdo), .hack(hack), .herr(herr), .hbusy(hbusy), .upen(upen),
        .upa(upa), .upws(upws), .uprs(uprs), .updi(updi), .updo(updo), .uprdy(uprdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mchk  = 1'b0;
    int n_rs  = 0;
    int n_ack = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one accepted request, a strobe cycle, waits, then one result pulse
    bit          m_act, m_strobe, m_rd, m_ack, m_err;
    logic [AB-1:0] m_a;
    logic [W-1:0]  m_d, m_hdo;
    int          m_wait;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 0; m_strobe = 0; m_rd = 0; m_ack = 0; m_err = 0;
            m_a = '0; m_d = '0; m_hdo = '0; m_wait = 0;
        end else if (m_ack || m_err) begin
            m_ack = 0; m_err = 0;
        end else if (!m_act) begin
            if (hcs) begin
                m_act = 1; m_strobe = 1; m_rd = hrnw; m_a = ha; m_d = hdi; m_wait = 0;
            end
        end else if (uprdy) begin
            m_act = 0; m_strobe = 0; m_ack = 1;
            if (m_rd) m_hdo = updo;
        end else if (TOUT_EN && !m_strobe && m_wait == LIMIT) begin
            m_act = 0; m_err = 1;
            if (m_rd) m_hdo = '0;
        end else begin
            m_strobe = 0;
            m_wait++;
        end
    end

    always @(negedge clk) begin
        if (mchk) begin
            chk("upen",  32'(upen),  32'(m_act));
            chk("upws",  32'(upws),  32'(m_act && m_strobe && !m_rd));
            chk("uprs",  32'(uprs),  32'(m_act && m_strobe && m_rd));
            chk("hack",  32'(hack),  32'(m_ack));
            chk("herr",  32'(herr),  32'(m_err));
            chk("hbusy", 32'(hbusy), 32'(m_act || m_ack || m_err));
            chk("hdo",   hdo,        m_hdo);
            chk("upa",   32'(upa),   32'(m_a));
            chk("updi",  updi,       m_d);
            if (uprs) n_rs++;
            if (hack) n_ack++;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    int rs0, ack0, k;
    bit seen;

    initial begin
        rst = 1; hcs = 0; hrnw = 0; ha = '0; hdi = '0; updo = '0; uprdy = 0;
        cyc(3);
        mchk = 1;
        chk("rst_hbusy", 32'(hbusy), 32'd0);
        chk("rst_hdo", hdo, 32'd0);
        rst = 0;

        // Write with minimum downstream response
        hcs = 1; hrnw = 0; ha = 5'h03; hdi = 32'hA5A5_0001;
        cyc; hcs = 0;
        chk("wr_upws_t1", 32'(upws), 32'd1);
        chk("wr_uprs_t1", 32'(uprs), 32'd0);
        chk("wr_upa", 32'(upa), 32'h3);
        chk("wr_updi", updi, 32'hA5A5_0001);
        cyc;
        chk("wr_upws_t2", 32'(upws), 32'd0);
        chk("wr_upen_t2", 32'(upen), 32'd1);
        cyc(2); uprdy = 1;
        chk("wr_upen_t4", 32'(upen), 32'd1);
        cyc; uprdy = 0;
        chk("wr_hack_t5", 32'(hack), 32'd1);
        chk("wr_upen_t5", 32'(upen), 32'd0);
        cyc;
        chk("wr_idle_t6", 32'(hbusy), 32'd0);

        // Read with a dropped second request during the access
        rs0 = n_rs; ack0 = n_ack;
        hcs = 1; hrnw = 1; ha = 5'h1F;
        cyc; hcs = 0;
        chk("rd_uprs_t1", 32'(uprs), 32'd1);
        cyc; hcs = 1; hrnw = 0; ha = 5'h02; hdi = 32'h1111_2222;
        cyc; hcs = 0;
        cyc(3); uprdy = 1; updo = 32'hDEAD_BEEF;
        cyc; uprdy = 0; updo = '0;
        chk("rd_hack_t7", 32'(hack), 32'd1);
        chk("rd_hdo_t7", hdo, 32'hDEAD_BEEF);
        cyc(3);
        chk("rd_one_uprs", 32'(n_rs - rs0), 32'd1);
        chk("rd_one_hack", 32'(n_ack - ack0), 32'd1);

        // Write answered during the strobe cycle keeps hdo; stray uprdy in idle is ignored
        hcs = 1; hrnw = 0; ha = 5'h07; hdi = 32'h0BAD_F00D;
        cyc; hcs = 0; uprdy = 1; updo = 32'h1234_5678;
        cyc; uprdy = 0;
        chk("wr_fast_hack", 32'(hack), 32'd1);
        chk("wr_keep_hdo", hdo, 32'hDEAD_BEEF);
        cyc; uprdy = 1;
        cyc; uprdy = 0; updo = '0;
        chk("idle_rdy_hdo", hdo, 32'hDEAD_BEEF);
        chk("idle_rdy_hack", 32'(hack), 32'd0);

`ifdef UPACC_TIMEOUT_EN
        // Read timeout: ERR after LIMIT wait cycles
        hcs = 1; hrnw = 1; ha = 5'h05;
        cyc; hcs = 0;
        k = 1; seen = 0;
        while (k < 40 && !seen) begin
            cyc; k++;
            if (herr) seen = 1;
        end
        chk("to_seen", 32'(seen), 32'd1);
        chk("to_cycle", 32'(k), 32'(LIMIT + 2));
        chk("to_upen", 32'(upen), 32'd0);
        chk("to_hdo", hdo, 32'd0);
        chk("to_hack", 32'(hack), 32'd0);
        cyc;
        // Response on the limit cycle wins over the timeout
        hcs = 1; hrnw = 1; ha = 5'h06;
        cyc(LIMIT + 1); hcs = 0;
        hcs = 0; uprdy = 1; updo = 32'h0000_0077;
        cyc; uprdy = 0;
        chk("tie_hack", 32'(hack), 32'd1);
        chk("tie_herr", 32'(herr), 32'd0);
        chk("tie_hdo", hdo, 32'h77);
        cyc;
`else
        // Without timeout a long wait never errors
        hcs = 1; hrnw = 1; ha = 5'h05;
        cyc; hcs = 0;
        cyc(40);
        chk("nto_busy", 32'(hbusy), 32'd1);
        chk("nto_herr", 32'(herr), 32'd0);
        uprdy = 1; updo = 32'hCAFE_0001;
        cyc; uprdy = 0;
        chk("nto_hack", 32'(hack), 32'd1);
        chk("nto_hdo", hdo, 32'hCAFE_0001);
        cyc;
`endif

        // Reset in the middle of an access abandons it
        hcs = 1; hrnw = 1; ha = 5'h09;
        cyc; hcs = 0;
        cyc; rst = 1;
        cyc; rst = 0;
        chk("mr_upen", 32'(upen), 32'd0);
        chk("mr_hbusy", 32'(hbusy), 32'd0);
        chk("mr_hdo", hdo, 32'd0);
        uprdy = 1; updo = 32'h5555_5555;
        cyc; uprdy = 0;
        chk("mr_hack", 32'(hack), 32'd0);
        chk("mr_hdo2", hdo, 32'd0);
        hcs = 1; hrnw = 0; ha = 5'h0A; hdi = 32'h0000_00AA;
        cyc; hcs = 0;
        chk("mr_new_upws", 32'(upws), 32'd1);
        chk("mr_new_upa", 32'(upa), 32'hA);
        cyc(2); uprdy = 1;
        cyc; uprdy = 0;
        chk("mr_new_hack", 32'(hack), 32'd1);
        cyc;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            hcs   = ($urandom_range(0, 3) == 0);
            hrnw  = 1'($urandom);
            ha    = AB'($urandom);
            hdi   = $urandom;
            uprdy = ($urandom_range(0, 4) == 0);
            updo  = $urandom;
            cyc;
        end
        rst = 0; hcs = 0; uprdy = 0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
